onchip_memory_pipelined: RTL and testbench
==========================================

# onchip_memory_pipelined

Parametrised single-port Avalon-MM on-chip RAM for the SOPC video system, the successor to the fixed 4096×32 unregistered memory. Adds configurable data width, depth and read latency, explicit `read`/`readdatavalid`/`waitrequest` handshaking, out-of-range address protection and an optional post-reset clearing sweep. It sits on the system interconnect as a slave for Nios II data/instruction or frame-metadata buffers.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 12: word-address width.
- `DEPTH`, 4096: number of implemented words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- `READ_LATENCY`, 2: cycles from read acceptance to `readdatavalid`; legal values 1..3.
- `CLEAR_ON_RESET`, 1: 1 = zero every word after reset before accepting commands; 0 = skip clearing.
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clken`  in  1  clock enable; when low, all state is frozen.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `address`  in  ADDR_WIDTH  word address.
- `byteenable`  in  DATA_WIDTH/8  per-byte write enable; bit i covers bits [8i+7:8i].
- `writedata`  in  DATA_WIDTH  write data.
- `readdata`  out  DATA_WIDTH  read data; valid only while `readdatavalid` is high.
- `readdatavalid`  out  1  one-cycle pulse per accepted read.
- `waitrequest`  out  1  high = the command is not accepted this cycle.
- `clear_busy`  out  1  high while the clearing sweep runs.

## Operation
- Acceptance: a command is accepted at a rising edge when `chipselect & (read | write) & !waitrequest`.
- `waitrequest = clear_busy | !clken`. It is combinational from `clken` and registered state.
- Write: for each byte with `byteenable[i]=1`, `mem[address]` byte i is updated at the acceptance edge. Bytes with `byteenable[i]=0` are unchanged.
- Read: `mem[address]` is sampled and enters a READ_LATENCY-deep valid/data pipeline. Byteenable is ignored on reads; the full word is returned.
- `read` and `write` both high: the write is performed and the read is dropped. No `readdatavalid` pulse is produced.
- Out of range (`address ≥ DEPTH`): writes are discarded. Reads are accepted and return all zeros with the normal `readdatavalid` timing.
- Clear FSM has two states, CLEAR and READY.
  - Reset enters CLEAR with the counter at 0 if `CLEAR_ON_RESET=1`; otherwise reset enters READY.
  - In CLEAR, each enabled cycle writes zero to `mem[counter]` and increments the counter.
  - After writing word DEPTH-1, the FSM goes to READY. `clear_busy` is high exactly while in CLEAR.
- `clken=0`: the pipeline, FSM, counter and memory writes all hold. `readdatavalid` and `readdata` hold their current values.
- Reset during CLEAR restarts the sweep from address 0.
- Reset with reads in flight discards all pending `readdatavalid` pulses.
- Memory contents are not touched by reset except through the sweep. With `CLEAR_ON_RESET=0`, contents survive reset.
- `readdata` holds its last value while `readdatavalid` is low. It is 0 after reset until the first valid read.

## Timing
- Reset values: `readdatavalid=0`, `readdata=0`, `clear_busy=CLEAR_ON_RESET`. `waitrequest` is 1 if `CLEAR_ON_RESET=1` or `clken=0`; otherwise it is 0.
- The clear sweep takes exactly DEPTH enabled cycles after the reset-release edge. `waitrequest` falls in the cycle after the final clear write.
- Read latency: `readdatavalid` is high exactly READ_LATENCY enabled cycles after the acceptance edge. Cycles with `clken=0` stretch the latency without losing data.
- Throughput: one command per cycle, with no bubbles. Back-to-back reads return back-to-back `readdatavalid` pulses, in order.
- Read-after-write to the same address:
  - A read accepted on the cycle after the write returns the new data.
  - The combined read+write case cannot occur because write takes priority.
- Write has zero visible latency: the data is present for any read accepted at a later edge.

## Test plan
- **Post-reset clear.** `DEPTH=16`, `CLEAR_ON_RESET=1`, memory preloaded with 0xA5A5A5A5. Pulse `reset`.
  - Required: `waitrequest` high for exactly 16 cycles.
  - Required: reads of addresses 0..15 then all return 0x00000000.
- **Byte-enable write.** Write 0x11223344 to address 5 with `byteenable=4'b1111`, then 0xAABBCCDD with `byteenable=4'b0101`.
  - Required: a read of address 5 returns 0x11BB33DD.
- **Pipelined reads.** `READ_LATENCY=2`, reads of addresses 0, 1, 2 on consecutive cycles.
  - Required: `readdatavalid` high on cycles +2, +3, +4 with the data of addresses 0, 1, 2 in order.
- **Clock-enable stall.** Read accepted, then `clken=0` for 3 cycles in flight.
  - Required: `readdatavalid` appears 2+3 cycles after acceptance with the correct data.
  - Required: `waitrequest` is high during the stall.
- **Out of range and conflicting command.** `DEPTH=3000`.
  - Write 0xFFFFFFFF to address 3500, then read address 3500. Required: 0x00000000 with a normal `readdatavalid` pulse.
  - Assert `read` and `write` together. Required: the write lands and no `readdatavalid` pulse is produced.
- **Reset mid-operation.**
  - Assert `reset` at sweep word 7. Required: `clear_busy` stays high for a full DEPTH cycles from the new release.
  - Assert `reset` with 2 reads in flight. Required: no `readdatavalid` pulse follows.

Source files
------------

// File: rtl/onchip_memory_pipelined.sv
// Single-port Avalon-MM on-chip RAM with byte enables, configurable read latency,
// out-of-range protection and an optional post-reset zeroing sweep.
module onchip_memory_pipelined #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned READ_LATENCY   = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic [DATA_WIDTH-1:0]     writedata,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic                      clear_busy
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]  DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        StClear,
        StReady
    } state_e;

    state_e                  state_q;
    logic                    clear_busy_q;
    logic [IDX_W-1:0]        clr_cnt_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    logic                    accept;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign clear_busy  = clear_busy_q;
    assign waitrequest = clear_busy_q | ~clken;

    // Reset blocks acceptance so contents are only ever touched by the sweep during reset.
    assign accept   = chipselect & (read | write) & ~waitrequest & ~reset;
    assign wr_acc   = accept & write;
    assign rd_acc   = accept & read & ~write;
    assign in_range = {1'b0, address} < DEPTH_A;
    assign idx      = address[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    // Clear sweep FSM: one zero write per enabled cycle, then READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR_ON_RESET ? StClear : StReady;
            clear_busy_q <= CLEAR_ON_RESET;
            clr_cnt_q    <= '0;
        end else if (clken) begin
            case (state_q)
                StClear: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q      <= StReady;
                        clear_busy_q <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q      <= StReady;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; no reset so contents survive when the sweep is disabled.
    always_ff @(posedge clk) begin
        if (clken && !reset) begin
            if (state_q == StClear) begin
                mem[clr_cnt_q] <= '0;
            end else if (wr_acc && in_range) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (byteenable[b]) begin
                        mem[idx][8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline; data stages only load on valid so the output holds its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else if (clken) begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Directed bench: dut_a has DEPTH=16 with clearing, dut_b has DEPTH=3000 without.
module tb_onchip_memory_pipelined;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clken, cs, read, write, sel;
    logic [11:0] address;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        cs_a, cs_b;
    logic [31:0] rd_a, rd_b, rd_s;
    logic        rdv_a, rdv_b, rdv_s, wr_a, wr_b, wr_s, cb_a, cb_b, cb_s;

    int vectors = 0;
    int errors  = 0;

    assign cs_a  = cs & ~sel;
    assign cs_b  = cs & sel;
    assign rd_s  = sel ? rd_b : rd_a;
    assign rdv_s = sel ? rdv_b : rdv_a;
    assign wr_s  = sel ? wr_b : wr_a;
    assign cb_s  = sel ? cb_b : cb_a;

    onchip_memory_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .chipselect(cs_a), .read(read),
        .write(write), .address(address), .byteenable(be), .writedata(wdata),
        .readdata(rd_a), .readdatavalid(rdv_a), .waitrequest(wr_a), .clear_busy(cb_a)
    );

    onchip_memory_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(3000), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .chipselect(cs_b), .read(read),
        .write(write), .address(address), .byteenable(be), .writedata(wdata),
        .readdata(rd_b), .readdatavalid(rdv_b), .waitrequest(wr_b), .clear_busy(cb_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; write = 1'b1; address = a; wdata = d; be = b;
        tick;
        cs = 1'b0; write = 1'b0; be = 4'h0;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d, output int lat);
        cs = 1'b1; read = 1'b1; address = a;
        tick;
        cs = 1'b0; read = 1'b0;
        lat = 1;
        while (!rdv_s && lat < 10) begin
            tick;
            lat++;
        end
        d = rd_s;
    endtask

    task automatic test_reset;
        int n;
        sel = 1'b0; reset = 1'b1; clken = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; be = '0; wdata = '0;
        tick;
        tick;
        vectors++; if (rdv_a !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", rdv_a); end
        vectors++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rd_a); end
        vectors++; if (cb_a !== 1'b1) begin errors++; $display("FAIL reset_busy_a got %b want 1", cb_a); end
        vectors++; if (wr_a !== 1'b1) begin errors++; $display("FAIL reset_wait_a got %b want 1", wr_a); end
        vectors++; if (cb_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b want 0", cb_b); end
        vectors++; if (wr_b !== 1'b0) begin errors++; $display("FAIL reset_wait_b got %b want 0", wr_b); end
        clken = 1'b0;
        #1;
        vectors++; if (wr_b !== 1'b1) begin errors++; $display("FAIL reset_wait_clken got %b want 1", wr_b); end
        clken = 1'b1;
        #1;
        reset = 1'b0;
        n = 0;
        while (wr_s && n < 100) begin n++; tick; end
        vectors++; if (n != 16) begin errors++; $display("FAIL sweep_len got %0d want 16", n); end
        vectors++; if (cb_a !== 1'b0) begin errors++; $display("FAIL sweep_done got %b want 0", cb_a); end
    endtask

    task automatic test_clear;
        logic [31:0] d;
        int lat, n, bad;
        for (int i = 0; i < 16; i++) do_write(12'(i), 32'hA5A5A5A5, 4'hF);
        do_read(12'd9, d, lat);
        vectors++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL preload got %h want a5a5a5a5", d); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n = 0;
        while (wr_s && n < 100) begin n++; tick; end
        vectors++; if (n != 16) begin errors++; $display("FAIL clear_wait got %0d want 16", n); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            do_read(12'(i), d, lat);
            vectors++;
            if (d !== 32'h0 || lat != 2) begin
                errors++;
                $display("FAIL clear_word%0d got %h lat %0d want 0 lat 2", i, d, lat);
            end
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] d;
        int lat;
        do_write(12'd5, 32'h11223344, 4'hF);
        do_write(12'd5, 32'hAABBCCDD, 4'b0101);
        do_read(12'd5, d, lat);
        vectors++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL byteen got %h want 11bb33dd", d); end
        vectors++; if (lat != 2) begin errors++; $display("FAIL byteen_lat got %0d want 2", lat); end
    endtask

    task automatic test_back_to_back;
        logic exp_v;
        for (int i = 0; i < 3; i++) do_write(12'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        cs = 1'b1; read = 1'b1; address = 12'd0;
        for (int c = 1; c <= 5; c++) begin
            tick;
            exp_v = (c >= 2 && c <= 4);
            vectors++;
            if (rdv_s !== exp_v) begin errors++; $display("FAIL b2b_vld c%0d got %b want %b", c, rdv_s, exp_v); end
            if (exp_v) begin
                vectors++;
                if (rd_s !== 32'hC0DE0000 + 32'(c - 2)) begin
                    errors++;
                    $display("FAIL b2b_data c%0d got %h want %h", c, rd_s, 32'hC0DE0000 + 32'(c - 2));
                end
            end
            if (c < 3) address = 12'(c);
            else begin cs = 1'b0; read = 1'b0; end
        end
    endtask

    task automatic test_read_after_write;
        logic [31:0] d;
        int lat;
        do_write(12'd7, 32'hDEADBEEF, 4'hF);
        do_write(12'd7, 32'h5EED1234, 4'hF);
        do_read(12'd7, d, lat);
        vectors++; if (d !== 32'h5EED1234) begin errors++; $display("FAIL raw got %h want 5eed1234", d); end
    endtask

    task automatic test_clken_stall;
        logic [31:0] d;
        int lat;
        cs = 1'b1; read = 1'b1; address = 12'd5;
        tick;
        cs = 1'b0; read = 1'b0; clken = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick;
            vectors++; if (rdv_s !== 1'b0) begin errors++; $display("FAIL stall_vld s%0d got %b want 0", s, rdv_s); end
            vectors++; if (wr_s !== 1'b1) begin errors++; $display("FAIL stall_wait s%0d got %b want 1", s, wr_s); end
        end
        clken = 1'b1;
        tick;
        vectors++; if (rdv_s !== 1'b1) begin errors++; $display("FAIL stall_out got %b want 1", rdv_s); end
        vectors++; if (rd_s !== 32'h11BB33DD) begin errors++; $display("FAIL stall_data got %h want 11bb33dd", rd_s); end
        clken = 1'b0;
        tick;
        vectors++; if (rdv_s !== 1'b1) begin errors++; $display("FAIL stall_hold got %b want 1", rdv_s); end
        clken = 1'b1;
        tick;
        vectors++; if (rdv_s !== 1'b0) begin errors++; $display("FAIL stall_drop got %b want 0", rdv_s); end
        vectors++; if (rd_s !== 32'h11BB33DD) begin errors++; $display("FAIL stall_keep got %h want 11bb33dd", rd_s); end
        // A command offered while clken is low must not be taken.
        clken = 1'b0; cs = 1'b1; write = 1'b1; address = 12'd5; wdata = 32'h0; be = 4'hF;
        tick;
        cs = 1'b0; write = 1'b0; clken = 1'b1;
        do_read(12'd5, d, lat);
        vectors++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL stall_nowrite got %h want 11bb33dd", d); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d;
        int lat;
        sel = 1'b1;
        do_write(12'd3500, 32'hFFFFFFFF, 4'hF);
        do_read(12'd3500, d, lat);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL oor_data got %h want 0", d); end
        vectors++; if (lat != 2) begin errors++; $display("FAIL oor_lat got %0d want 2", lat); end
        do_write(12'd2999, 32'hCAFEF00D, 4'hF);
        do_write(12'd3000, 32'h0BADF00D, 4'hF);
        do_read(12'd2999, d, lat);
        vectors++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word got %h want cafef00d", d); end
        do_read(12'd3000, d, lat);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL first_oor got %h want 0", d); end
    endtask

    task automatic test_conflict;
        logic [31:0] d;
        int lat;
        logic seen;
        sel = 1'b1;
        cs = 1'b1; read = 1'b1; write = 1'b1; address = 12'd10; wdata = 32'h12345678; be = 4'hF;
        tick;
        cs = 1'b0; read = 1'b0; write = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (rdv_s) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL conflict_vld got %b want 0", seen); end
        do_read(12'd10, d, lat);
        vectors++; if (d !== 32'h12345678) begin errors++; $display("FAIL conflict_write got %h want 12345678", d); end
    endtask

    task automatic test_reset_survive;
        logic [31:0] d;
        int lat;
        sel = 1'b1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        vectors++; if (wr_s !== 1'b0) begin errors++; $display("FAIL noclear_wait got %b want 0", wr_s); end
        do_read(12'd10, d, lat);
        vectors++; if (d !== 32'h12345678) begin errors++; $display("FAIL survive got %h want 12345678", d); end
    endtask

    task automatic test_reset_mid_sweep;
        logic [31:0] d;
        int lat, n;
        sel = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int k = 0; k < 7; k++) tick;
        vectors++; if (cb_s !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", cb_s); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n = 0;
        while (cb_s && n < 100) begin n++; tick; end
        vectors++; if (n != 16) begin errors++; $display("FAIL restart_len got %0d want 16", n); end
        do_read(12'd5, d, lat);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL restart_zero got %h want 0", d); end
    endtask

    task automatic test_reset_inflight;
        logic seen;
        sel = 1'b0;
        do_write(12'd3, 32'h77777777, 4'hF);
        cs = 1'b1; read = 1'b1; address = 12'd3;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0; cs = 1'b0; read = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (rdv_s) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL inflight_vld got %b want 0", seen); end
        vectors++; if (rd_s !== 32'h0) begin errors++; $display("FAIL inflight_data got %h want 0", rd_s); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_enable();
        test_back_to_back();
        test_read_after_write();
        test_clken_stall();
        test_out_of_range();
        test_conflict();
        test_reset_survive();
        test_reset_mid_sweep();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

endmodule
